nand_gate: RTL and testbench
============================

# nand_gate

Bitwise two-input NAND primitive for the logic-gate library, with an optional registered output stage and a truth-table coverage monitor. The combinational output `y` is the gate itself and settles within the same time step as its inputs. The clocked side (`y_q`, `out_valid`, `cov`) lets pipelined datapaths and self-checking benches consume the gate without extra glue logic.

## Interface
- `WIDTH`, default 1: number of independent NAND lanes; must be ≥ 1.
- `REG_OUT`, default 1: 1 builds the registered output stage; 0 ties `y_q` to `y` and `out_valid` to `in_valid`, combinationally.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `a` input, WIDTH bits: operand A.
- `b` input, WIDTH bits: operand B.
- `in_valid` input, 1 bit: qualifies `a`/`b` for the registered stage and the coverage monitor.
- `y` output, WIDTH bits: combinational `~(a & b)`, bitwise.
- `y_q` output, WIDTH bits: registered `~(a & b)`, captured when `in_valid` is 1.
- `out_valid` output, 1 bit: `y_q` holds a fresh result this cycle.
- `cov` output, 4 bits: sticky lane-0 truth-table coverage. Bit index = {b[0], a[0]}.
- `cov_done` output, 1 bit: 1 when `cov` == 4'b1111.

## Operation
- `y[i] = ~(a[i] & b[i])` for every lane. Truth table per lane: 00→1, 01→1, 10→1, 11→0.
- `y` is purely combinational. It does not depend on `clk`, `rst_n` or `in_valid`.
- `y` is never X when both inputs are 0/1.
- Registered stage (REG_OUT=1), on each rising edge:
  - `rst_n`=0: `y_q` ← all ones; `out_valid` ← 0.
  - else if `in_valid`=1: `y_q` ← `~(a & b)`; `out_valid` ← 1.
  - else: `y_q` holds; `out_valid` ← 0.
- Coverage monitor, on each rising edge:
  - `rst_n`=0: `cov` ← 0.
  - else if `in_valid`=1: `cov[{b[0],a[0]}]` ← 1. Other bits hold; bits are never cleared except by reset.
- `cov_done` is combinational from `cov`.
- Lanes are independent. No carries and no cross-lane interaction.
- `in_valid`=0 leaves all state unchanged except clearing `out_valid`.

## Timing
- `y` latency: zero cycles. It is valid within the same simulation step as the input change. Sampling 1 ns after an input change must show the final value.
- `y_q`/`out_valid` latency: 1 cycle from the edge that samples `in_valid`=1. Throughput is one result per cycle; back-to-back valids are allowed.
- Reset values: `y_q` = all ones, `out_valid` = 0, `cov` = 4'b0000, `cov_done` = 0. `y` follows its inputs even during reset.
- Reset mid-operation:
  - An `in_valid` on the same edge as `rst_n`=0 is discarded.
  - The first capture is on the first edge where `rst_n`=1.
- REG_OUT=0: `y_q` and `out_valid` have zero latency. `cov` still updates on the clock.

## Test plan
- Exhaustive combinational, WIDTH=1: step (a,b) through 00,10,01,11 at 10 ns intervals and check `y` 1 ns after each step → 1,1,1,0.
- Registered path: reset, then `in_valid`=1 with a=1,b=1 on edge N → `y_q`=0, `out_valid`=1 after edge N. Next cycle `in_valid`=0 → `y_q` holds 0, `out_valid`=0.
- Coverage: drive all four lane-0 combinations with `in_valid`=1 → `cov` walks to 4'b1111 and `cov_done`=1. Assert `rst_n`=0 for one edge → `cov`=0, `cov_done`=0, `y_q`=1.
- WIDTH=8: a=8'hF0, b=8'hAA → `y`=8'h5F combinationally, and `y_q`=8'h5F one cycle after `in_valid`.
- Reset collision: `rst_n`=0 and `in_valid`=1 with a=b=1 on the same edge → `y_q`=1, `out_valid`=0, `cov` bit 3 stays 0.

Source files
------------

// File: rtl/nand_gate_if.sv
// nand_gate operand/result bundle.
// master drives operands, slave is the gate.
interface nand_gate_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic [3:0]       cov;
  logic             cov_done;

  modport master (
    output a, b, in_valid,
    input  y, y_q, out_valid, cov, cov_done
  );

  modport slave (
    input  a, b, in_valid,
    output y, y_q, out_valid, cov, cov_done
  );
endinterface

// File: rtl/nand_gate.sv
// Bitwise NAND with optional registered stage
// and sticky lane-0 truth-table coverage.
module nand_gate #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  nand_gate_if.slave   gate
);

  logic [WIDTH-1:0] nand_y;
  logic [3:0]       cov_r;
  logic [1:0]       cov_idx;

  // the gate itself, lanes fully independent
  assign nand_y = ~(gate.a & gate.b);
  assign gate.y = nand_y;

  assign cov_idx = {gate.b[0], gate.a[0]};

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] y_q_r;
      logic             out_valid_r;

      // capture on valid, hold otherwise; valid pulses per capture
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          y_q_r       <= '1;
          out_valid_r <= 1'b0;
        end else if (gate.in_valid) begin
          y_q_r       <= nand_y;
          out_valid_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
        end
      end

      assign gate.y_q       = y_q_r;
      assign gate.out_valid = out_valid_r;
    end else begin : g_comb
      assign gate.y_q       = nand_y;
      assign gate.out_valid = gate.in_valid;
    end
  endgenerate

  // sticky coverage: set the seen {b0,a0} row, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cov_r <= 4'b0000;
    end else if (gate.in_valid) begin
      cov_r[cov_idx] <= 1'b1;
    end
  end

  assign gate.cov      = cov_r;
  assign gate.cov_done = &cov_r;

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate: directed
// vector table, random stimulus vs reference model.
module tb_nand_gate;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nand_gate_if #(.WIDTH(8)) bus8 ();
  nand_gate_if #(.WIDTH(1)) bus1 ();

  nand_gate #(.WIDTH(8), .REG_OUT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .gate(bus8.slave)
  );
  nand_gate #(.WIDTH(1), .REG_OUT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .gate(bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] m_yq;
  logic       m_ov;
  bit         seen [4];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic       r;
    logic [7:0] y;
    logic [7:0] yq;
    logic       ov;
    logic [3:0] cov;
  } vec_t;

  vec_t tab [10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // per lane: output is 0 only when both inputs are 1
  function automatic logic [7:0] ref_nand(logic [7:0] a, logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = ((int'(a[i]) + int'(b[i])) == 2) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] ref_cov();
    logic [3:0] c;
    for (int i = 0; i < 4; i++) c[i] = seen[i];
    return c;
  endfunction

  function automatic logic ref_done();
    return seen[0] && seen[1] && seen[2] && seen[3];
  endfunction

  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic v, input logic r);
    logic [7:0] ey;
    @(negedge clk);
    rst_n = r;
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = v;
    bus1.a = a[0];
    bus1.b = b[0];
    bus1.in_valid = v;
    #1;
    ey = ref_nand(a, b);
    chk("y8_comb", 32'(bus8.y), 32'(ey));
    chk("y1_comb", 32'(bus1.y), 32'(ey[0]));
    chk("y1_q_comb", 32'(bus1.y_q), 32'(ey[0]));
    chk("ov1_comb", 32'(bus1.out_valid), 32'(v));
    @(posedge clk);
    if (!r) begin
      m_yq = '1;
      m_ov = 1'b0;
      for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    end else if (v) begin
      m_yq = ey;
      m_ov = 1'b1;
      seen[int'(b[0]) * 2 + int'(a[0])] = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    #1;
    chk("y_q8", 32'(bus8.y_q), 32'(m_yq));
    chk("ov8", 32'(bus8.out_valid), 32'(m_ov));
    chk("cov8", 32'(bus8.cov), 32'(ref_cov()));
    chk("cov_done8", 32'(bus8.cov_done), 32'(ref_done()));
    chk("cov1", 32'(bus1.cov), 32'(ref_cov()));
    chk("cov_done1", 32'(bus1.cov_done), 32'(ref_done()));
  endtask

  initial begin
    bus8.a = '0;
    bus8.b = '0;
    bus8.in_valid = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.in_valid = 1'b0;
    m_yq = '1;
    m_ov = 1'b0;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;

    //        a      b      v     r     y      yq     ov    cov
    tab[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 4'b0000};
    tab[1] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 4'b0001};
    tab[2] = '{8'h01, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 4'b0011};
    tab[3] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 4'b0111};
    tab[4] = '{8'h01, 8'h01, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b1, 4'b1111};
    tab[5] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 8'hFE, 1'b0, 4'b1111};
    tab[6] = '{8'hF0, 8'hAA, 1'b1, 1'b1, 8'h5F, 8'h5F, 1'b1, 4'b1111};
    tab[7] = '{8'h11, 8'h11, 1'b1, 1'b0, 8'hEE, 8'hFF, 1'b0, 4'b0000};
    tab[8] = '{8'h01, 8'h01, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b1, 4'b1000};
    tab[9] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 8'hFE, 1'b0, 4'b1000};

    for (int i = 0; i < 10; i++) begin
      step(tab[i].a, tab[i].b, tab[i].v, tab[i].r);
      chk($sformatf("tab%0d_y", i), 32'(bus8.y), 32'(tab[i].y));
      chk($sformatf("tab%0d_yq", i), 32'(bus8.y_q), 32'(tab[i].yq));
      chk($sformatf("tab%0d_ov", i), 32'(bus8.out_valid), 32'(tab[i].ov));
      chk($sformatf("tab%0d_cov", i), 32'(bus8.cov), 32'(tab[i].cov));
      chk($sformatf("tab%0d_done", i), 32'(bus8.cov_done),
          32'(tab[i].cov == 4'b1111));
    end

    // back-to-back valids over all lane-0 rows, then a one-edge reset
    step(8'h00, 8'h00, 1'b1, 1'b1);
    step(8'h01, 8'h00, 1'b1, 1'b1);
    step(8'h00, 8'h01, 1'b1, 1'b1);
    step(8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("walk_yq", 32'(bus8.y_q), 32'h00);
    chk("walk_cov", 32'(bus8.cov), 32'hF);
    chk("walk_done", 32'(bus8.cov_done), 32'h1);
    step(8'h3C, 8'h0F, 1'b0, 1'b0);
    chk("rst_cov", 32'(bus8.cov), 32'h0);
    chk("rst_done", 32'(bus8.cov_done), 32'h0);
    chk("rst_yq", 32'(bus8.y_q), 32'hFF);
    chk("rst_ov", 32'(bus8.out_valid), 32'h0);
    chk("rst_y", 32'(bus8.y), 32'hF3);

    // random stimulus against the model
    for (int n = 0; n < 300; n++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 15) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
